// File: rtl/wb_common_pkg.sv
`default_nettype none
// ============================================================================
// wb_common_pkg: shared Wishbone B3 cycle/burst encodings and address helper.
// Rev 1.0
// ============================================================================
package wb_common_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      BURST  = 2'd2
   } wb_state_t;

   // Word-address increment; linear wraps at the caller's address width.
   function automatic logic [31:0] wb_next_adr(input logic [31:0] adr,
                                               input logic [1:0]  bte);
      logic [31:0] nxt;
      logic [1:0]  lo2;
      logic [2:0]  lo3;
      logic [3:0]  lo4;
      lo2 = adr[1:0] + 2'd1;
      lo3 = adr[2:0] + 3'd1;
      lo4 = adr[3:0] + 4'd1;
      case (bte)
         BTE_WRAP4:  nxt = {adr[31:2], lo2};
         BTE_WRAP8:  nxt = {adr[31:3], lo3};
         BTE_WRAP16: nxt = {adr[31:4], lo4};
         default:    nxt = adr + 32'd1;
      endcase
      return nxt;
   endfunction

   function automatic logic wb_cti_reserved(input logic [2:0] cti);
      return !(cti == CTI_CLASSIC || cti == CTI_CONST ||
               cti == CTI_INC     || cti == CTI_EOB);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bram_core.sv
`default_nettype none
// ============================================================================
// wb_bram_core: DEPTH x 32 single-port sync-read RAM, per-byte write, read-first.
// Rev 1.0
// ============================================================================
module wb_bram_core #(
   parameter int DEPTH = 1024,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_adr,
   input  logic [31:0]   i_wdat,
   output logic [31:0]   o_rdat
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdat;

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b]) begin
            r_mem[i_adr][8*b +: 8] <= i_wdat[8*b +: 8];
         end
      end
   end

   // Output register reset maps onto the block-RAM output-latch reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rdat <= '0;
      end else begin
         r_rdat <= r_mem[i_adr];
      end
   end

   assign o_rdat = r_rdat;

endmodule
`default_nettype wire

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// wb_ram_slave: Wishbone B3 RAM slave with classic cycles and CTI/BTE bursts.
// Rev 1.0
// ============================================================================
module wb_ram_slave
   import wb_common_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o,
   output logic        wbs_rty_o
);

   localparam int AW = $clog2(DEPTH);

   wb_state_t   r_state;
   logic        r_ack;
   logic        r_err;
   logic [AW-1:0] r_adr;

   logic          w_req;
   logic [AW-1:0] w_adr_in;
   logic [31:0]   w_nxt32;
   logic [AW-1:0] w_adr_nxt;
   logic [AW-1:0] w_ram_adr;
   logic [3:0]    w_ram_we;
   logic          w_unused_bits;

   assign w_req     = wbs_cyc_i & wbs_stb_i;
   assign w_adr_in  = wbs_adr_i[AW+1:2];
   assign w_nxt32   = wb_next_adr({{(32-AW){1'b0}}, r_adr}, wbs_bte_i);
   assign w_adr_nxt = w_nxt32[AW-1:0];
   assign w_unused_bits = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0], w_nxt32[31:AW]};

   // One RAM port: write beats use it for the write, read beats prefetch the next word.
   always_comb begin
      w_ram_adr = w_adr_in;
      case (r_state)
         SINGLE:  w_ram_adr = r_adr;
         BURST:   w_ram_adr = (w_req & wbs_we_i) ? r_adr : w_adr_nxt;
         default: w_ram_adr = w_adr_in;
      endcase
   end

   assign w_ram_we = (r_ack & w_req & wbs_we_i) ? wbs_sel_i : 4'b0000;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_adr   <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req & ~r_ack & ~r_err) begin
                  if (wb_cti_reserved(wbs_cti_i)) begin
                     r_err <= 1'b1;
                  end else begin
                     r_ack   <= 1'b1;
                     r_adr   <= w_adr_in;
                     r_state <= (wbs_cti_i == CTI_INC) ? BURST : SINGLE;
                  end
               end
            end
            SINGLE: begin
               r_ack   <= 1'b0;
               r_state <= IDLE;
            end
            BURST: begin
               if (w_req) begin
                  r_adr <= w_adr_nxt;
                  if (wbs_cti_i != CTI_INC) begin
                     r_ack   <= 1'b0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_ack   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   wb_bram_core #(.DEPTH(DEPTH)) u_ram (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_we    (w_ram_we),
      .i_adr   (w_ram_adr),
      .i_wdat  (wbs_dat_i),
      .o_rdat  (wbs_dat_o)
   );

   assign wbs_ack_o = r_ack & w_req;
   assign wbs_err_o = r_err & w_req;
   assign wbs_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// tb_wb_ram_slave: directed self-checking bench for wb_ram_slave.
// Rev 1.0
// ============================================================================
module tb_wb_ram_slave;
   import wb_common_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] adr, dat_w, dat_r;
   logic [3:0]  sel;
   logic        we, cyc, stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack, err, rty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_ram_slave #(.DEPTH(DEPTH)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_w),
      .wbs_sel_i (sel),
      .wbs_we_i  (we),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_cti_i (cti),
      .wbs_bte_i (bte),
      .wbs_dat_o (dat_r),
      .wbs_ack_o (ack),
      .wbs_err_o (err),
      .wbs_rty_o (rty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drv(input logic s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl,
                      input logic [2:0] c, input logic [1:0] b);
      cyc = s; stb = s; we = w; adr = a; dat_w = d; sel = sl; cti = c; bte = b;
   endtask

   task automatic classic(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] sl,
                          input logic [31:0] exp);
      tick(); drv(1'b1, w, a, d, sl, CTI_CLASSIC, BTE_LINEAR);
      smp();  chk({tag, " wait"}, {31'd0, ack}, 32'd0);
      tick(); smp();
      chk({tag, " ack"}, {31'd0, ack}, 32'd1);
      if (!w) chk({tag, " data"}, dat_r, exp);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      drv(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, CTI_INC, BTE_LINEAR);
      tick(); tick(); smp();
      chk("reset ack", {31'd0, ack}, 32'd0);
      chk("reset err", {31'd0, err}, 32'd0);
      chk("reset dat", dat_r, 32'd0);
      chk("rty tied", {31'd0, rty}, 32'd0);
      tick(); rst_n = 1'b1;
      drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);

      // Classic write with back-to-back repeat: ack pattern 0,1,0,1
      tick(); drv(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR);
      smp();  chk("wr wait", {31'd0, ack}, 32'd0);
      tick(); smp(); chk("wr ack", {31'd0, ack}, 32'd1);
      tick(); smp(); chk("wr ack low", {31'd0, ack}, 32'd0);
      tick(); smp(); chk("wr b2b ack", {31'd0, ack}, 32'd1);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);

      classic("rd 0x10", 32'h10, 1'b0, 32'd0, 4'hF, 32'hDEADBEEF);
      classic("bytewr", 32'h10, 1'b1, 32'h0000AB00, 4'b0010, 32'd0);
      classic("rd byte", 32'h10, 1'b0, 32'd0, 4'hF, 32'hDEADABEF);

      for (int i = 0; i < 4; i++)
         classic("preload", 32'h10 + 32'(4*i), 1'b1, 32'(i + 1), 4'hF, 32'd0);

      // Wrap4 read burst from word 6: 3,4,1,2
      tick(); drv(1'b1, 1'b0, 32'h18, 32'd0, 4'hF, CTI_INC, BTE_WRAP4);
      smp();  chk("w4 wait", {31'd0, ack}, 32'd0);
      tick(); smp(); chk("w4 b1 ack", {31'd0, ack}, 32'd1); chk("w4 b1", dat_r, 32'd3);
      tick(); smp(); chk("w4 b2 ack", {31'd0, ack}, 32'd1); chk("w4 b2", dat_r, 32'd4);
      tick(); smp(); chk("w4 b3 ack", {31'd0, ack}, 32'd1); chk("w4 b3", dat_r, 32'd1);
      tick(); cti = CTI_EOB;
      smp();  chk("w4 b4 ack", {31'd0, ack}, 32'd1); chk("w4 b4", dat_r, 32'd2);
      tick(); smp(); chk("w4 end ack", {31'd0, ack}, 32'd0);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      tick();

      // Linear write burst crossing the top of the RAM
      tick(); drv(1'b1, 1'b1, 32'((DEPTH-2)*4), 32'hAAAA0001, 4'hF, CTI_INC, BTE_LINEAR);
      smp();  chk("lin wait", {31'd0, ack}, 32'd0);
      tick(); smp(); chk("lin b1 ack", {31'd0, ack}, 32'd1);
      tick(); dat_w = 32'hBBBB0002; smp(); chk("lin b2 ack", {31'd0, ack}, 32'd1);
      tick(); dat_w = 32'hCCCC0003; smp(); chk("lin b3 ack", {31'd0, ack}, 32'd1);
      tick(); dat_w = 32'hDDDD0004; cti = CTI_EOB;
      smp();  chk("lin b4 ack", {31'd0, ack}, 32'd1);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      classic("lin rdA", 32'((DEPTH-2)*4), 1'b0, 32'd0, 4'hF, 32'hAAAA0001);
      classic("lin rdB", 32'((DEPTH-1)*4), 1'b0, 32'd0, 4'hF, 32'hBBBB0002);
      classic("lin rdC", 32'h0, 1'b0, 32'd0, 4'hF, 32'hCCCC0003);
      classic("lin rdD", 32'h4, 1'b0, 32'd0, 4'hF, 32'hDDDD0004);

      // Reserved CTI: one-cycle err, no ack, no write
      tick(); drv(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 3'b011, BTE_LINEAR);
      smp();  chk("rsv wait err", {31'd0, err}, 32'd0);
      tick(); smp(); chk("rsv err", {31'd0, err}, 32'd1); chk("rsv no ack", {31'd0, ack}, 32'd0);
      tick(); smp(); chk("rsv err low", {31'd0, err}, 32'd0); chk("rsv no ack2", {31'd0, ack}, 32'd0);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      tick();
      classic("rsv unchanged", 32'h10, 1'b0, 32'd0, 4'hF, 32'd1);

      // Stb dropped mid-burst, then restart with a fresh wait state
      tick(); drv(1'b1, 1'b0, 32'h14, 32'd0, 4'hF, CTI_INC, BTE_LINEAR);
      tick(); smp(); chk("drop b1", dat_r, 32'd2);
      tick(); stb = 1'b0; smp(); chk("drop ack", {31'd0, ack}, 32'd0);
      tick(); stb = 1'b1; adr = 32'h18; smp(); chk("restart wait", {31'd0, ack}, 32'd0);
      tick(); smp(); chk("restart ack", {31'd0, ack}, 32'd1); chk("restart b1", dat_r, 32'd3);
      tick(); cti = CTI_EOB; smp(); chk("restart b2", dat_r, 32'd4);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      tick();

      // Reset asserted during the second beat of a read burst
      tick(); drv(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, CTI_INC, BTE_LINEAR);
      tick(); smp(); chk("rst b1", dat_r, 32'd1);
      tick(); rst_n = 1'b0; smp(); chk("rst b2 ack", {31'd0, ack}, 32'd1); chk("rst b2", dat_r, 32'd2);
      tick(); rst_n = 1'b1; smp();
      chk("post rst ack", {31'd0, ack}, 32'd0);
      chk("post rst err", {31'd0, err}, 32'd0);
      chk("post rst dat", dat_r, 32'd0);
      tick(); drv(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
      tick();
      classic("post rst rd", 32'h10, 1'b0, 32'd0, 4'hF, 32'd1);
      classic("post rst rdC", 32'h0, 1'b0, 32'd0, 4'hF, 32'hCCCC0003);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
